// File: rtl/call_stack_unit_if.sv
// Push/pop control and top-of-stack status bundle between Controller/DataPath
// and call_stack_unit.
interface call_stack_unit_if #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic              clear_err;
    logic [DATA_W-1:0] top_data;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, push_data, clear_err,
        input  top_data, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, push_data, clear_err,
        output top_data, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/call_stack_unit.sv
// Parametrised return-address/data stack with replace-top, occupancy count and
// sticky error flags. Define CALL_STACK_WRAP_EN to let a push while full overwrite the oldest entry.
module call_stack_unit #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    call_stack_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              ovf_evt, unf_evt;
    logic              we;
    logic [PTR_W-1:0]  waddr, top_idx, nxt_idx;
    logic              is_empty, is_full;

    // Operands stay below 2*DEPTH, so a single conditional subtract is an exact mod.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] r;
        r = (s >= DEPTH_S) ? s - DEPTH_S : s;
        return r[PTR_W-1:0];
    endfunction

    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CNT_W'(DEPTH));
    assign nxt_idx  = wrap_idx(SUM_W'(base_q) + SUM_W'(cnt_q));
    // Meaningless when empty; the output mux below masks it.
    assign top_idx  = wrap_idx(SUM_W'(base_q) + SUM_W'(cnt_q) - SUM_W'(1));

    always_comb begin
        base_d  = base_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        waddr   = nxt_idx;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        case ({bus.push, bus.pop})
            2'b11: begin
                we = 1'b1;
                if (is_empty) begin
                    cnt_d   = CNT_W'(1);
                    unf_evt = 1'b1;
                end else begin
                    waddr = top_idx;
                end
            end
            2'b10: begin
                if (!is_full) begin
                    we    = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    ovf_evt = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                    // When full, nxt_idx equals base_q: overwrite the oldest slot.
                    we     = 1'b1;
                    base_d = wrap_idx(SUM_W'(base_q) + SUM_W'(1));
`endif
                end
            end
            2'b01: begin
                if (!is_empty) cnt_d = cnt_q - CNT_W'(1);
                else           unf_evt = 1'b1;
            end
            default: ;
        endcase
        ovf_d = (ovf_q & ~bus.clear_err) | ovf_evt;
        unf_d = (unf_q & ~bus.clear_err) | unf_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && we) mem_q[waddr] <= bus.push_data;
    end

    assign bus.top_data  = is_empty ? '0 : mem_q[top_idx];
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.count     = cnt_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_call_stack_unit.sv
// Bench for call_stack_unit: DEPTH=8 and DEPTH=5 instances share stimulus and are
// checked every cycle against an array-based LIFO model.
module tb_call_stack_unit;
    localparam int DW = 12;
`ifdef CALL_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic p_s = 1'b0, po_s = 1'b0, c_s = 1'b0;
    logic [DW-1:0] d_s = '0;
    always #5 clk = ~clk;

    call_stack_unit_if #(.DATA_W(DW), .DEPTH(8)) b8();
    call_stack_unit_if #(.DATA_W(DW), .DEPTH(5)) b5();
    assign b8.push = p_s;  assign b8.pop = po_s;  assign b8.push_data = d_s;  assign b8.clear_err = c_s;
    assign b5.push = p_s;  assign b5.pop = po_s;  assign b5.push_data = d_s;  assign b5.clear_err = c_s;

    call_stack_unit #(.DATA_W(DW), .DEPTH(8)) u8 (.clk(clk), .reset(reset), .bus(b8));
    call_stack_unit #(.DATA_W(DW), .DEPTH(5)) u5 (.clk(clk), .reset(reset), .bus(b5));

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    // Model: ms[k][0] is the oldest entry, ms[k][mc[k]-1] the top.
    logic [DW-1:0] ms [2][8];
    int mc [2];
    bit mo [2], mu [2];

    function automatic int dep(input int k);
        return (k == 0) ? 8 : 5;
    endfunction

    function automatic logic [DW-1:0] mtop(input int k);
        return (mc[k] == 0) ? '0 : ms[k][mc[k]-1];
    endfunction

    function automatic logic [19:0] mexp(input int k);
        return {mtop(k), 4'(mc[k]), mc[k] == 0, mc[k] == dep(k), mo[k], mu[k]};
    endfunction

    task automatic mdl(input int k, input bit r, input bit p, input bit po,
                       input logic [DW-1:0] d, input bit c);
        bit oe, ue;
        oe = 1'b0;
        ue = 1'b0;
        if (r) begin
            mc[k] = 0; mo[k] = 1'b0; mu[k] = 1'b0;
        end else begin
            if (p && po) begin
                if (mc[k] == 0) begin ms[k][0] = d; mc[k] = 1; ue = 1'b1; end
                else ms[k][mc[k]-1] = d;
            end else if (p) begin
                if (mc[k] < dep(k)) begin ms[k][mc[k]] = d; mc[k]++; end
                else begin
                    oe = 1'b1;
                    if (WRAP) begin
                        for (int i = 0; i < dep(k) - 1; i++) ms[k][i] = ms[k][i+1];
                        ms[k][dep(k)-1] = d;
                    end
                end
            end else if (po) begin
                if (mc[k] > 0) mc[k]--;
                else ue = 1'b1;
            end
            mo[k] = (mo[k] && !c) || oe;
            mu[k] = (mu[k] && !c) || ue;
        end
    endtask

    task automatic step(input bit r, input bit p, input bit po,
                        input logic [DW-1:0] d, input bit c);
        @(negedge clk);
        reset = r; p_s = p; po_s = po; d_s = d; c_s = c;
        @(posedge clk);
        mdl(0, r, p, po, d, c);
        mdl(1, r, p, po, d, c);
        #1;
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Per-cycle compare of {top,count,empty,full,overflow,underflow}.
    always @(negedge clk) begin
        if (armed) begin
            checks += 2;
            if ({b8.top_data, b8.count, b8.empty, b8.full, b8.overflow, b8.underflow} !== mexp(0)) begin
                errors++;
                $display("FAIL dut8 t=%0t got=%h want=%h", $time,
                         {b8.top_data, b8.count, b8.empty, b8.full, b8.overflow, b8.underflow}, mexp(0));
            end
            if ({b5.top_data, 1'b0, b5.count, b5.empty, b5.full, b5.overflow, b5.underflow} !== mexp(1)) begin
                errors++;
                $display("FAIL dut5 t=%0t got=%h want=%h", $time,
                         {b5.top_data, 1'b0, b5.count, b5.empty, b5.full, b5.overflow, b5.underflow}, mexp(1));
            end
        end
    end

    initial begin
        step(1, 1, 0, 12'h3c3, 0);
        armed = 1'b1;
        step(1, 0, 0, 0, 0);
        lit("rst_cnt", b8.count, 0);
        lit("rst_empty", b8.empty, 1);
        lit("rst_top", b8.top_data, 0);
        lit("rst_flags", {b8.overflow, b8.underflow}, 0);

        // Basic LIFO
        for (int i = 1; i <= 3; i++) step(0, 1, 0, DW'(i), 0);
        lit("lifo_cnt", b8.count, 3);
        lit("lifo_top", b8.top_data, 3);
        lit("model_top", mtop(0), 3);
        step(0, 0, 1, 0, 0); lit("lifo_pop1", b8.top_data, 2);
        step(0, 0, 1, 0, 0); lit("lifo_pop2", b8.top_data, 1);
        step(0, 0, 1, 0, 0); lit("lifo_pop3", b8.top_data, 0);
        lit("lifo_empty", b8.empty, 1);
        lit("lifo_flags", {b8.overflow, b8.underflow}, 0);

        // Full and overflow
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, DW'(12'h010 + i), 0);
        lit("full_flag", b8.full, 1);
        lit("full_cnt", b8.count, 8);
        step(0, 1, 0, 12'h0aa, 0);
        lit("ovf_top", b8.top_data, WRAP ? 12'h0aa : 12'h017);
        lit("ovf_cnt", b8.count, 8);
        lit("ovf_flag", b8.overflow, 1);
        lit("model_ovf_top", mtop(0), WRAP ? 12'h0aa : 12'h017);
        step(0, 0, 1, 0, 0);
        lit("ovf_pop1", b8.top_data, WRAP ? 12'h017 : 12'h016);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
        lit("ovf_pop7", b8.top_data, WRAP ? 12'h011 : 12'h010);
        step(0, 0, 1, 0, 0);
        lit("ovf_drained", b8.empty, 1);

        // Underflow and clear_err priority
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        lit("unf_set", b8.underflow, 1);
        lit("unf_cnt", b8.count, 0);
        step(0, 0, 0, 0, 1);
        lit("unf_clr", b8.underflow, 0);
        step(0, 0, 1, 0, 1);
        lit("unf_err_wins", b8.underflow, 1);

        // Replace-top
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 12'h100, 0);
        step(0, 1, 0, 12'h200, 0);
        step(0, 1, 1, 12'h300, 0);
        lit("rep_cnt", b8.count, 2);
        lit("rep_top", b8.top_data, 12'h300);
        step(0, 0, 1, 0, 0);
        lit("rep_pop", b8.top_data, 12'h100);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 12'h055, 0);
        lit("rep_empty_cnt", b8.count, 1);
        lit("rep_empty_top", b8.top_data, 12'h055);
        lit("rep_empty_unf", b8.underflow, 1);

        // Reset mid-burst
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, DW'(12'h0c0 + i), 0);
        step(1, 1, 0, 12'h0ff, 0);
        lit("mrst_cnt", b8.count, 0);
        lit("mrst_empty", b8.empty, 1);
        lit("mrst_top", b8.top_data, 0);
        lit("mrst_flags", {b8.overflow, b8.underflow}, 0);

        // Non-power-of-two depth
        for (int i = 1; i <= 7; i++) step(0, 1, 0, DW'(i), 0);
        lit("d5_top", b5.top_data, WRAP ? 7 : 5);
        lit("d5_ovf", b5.overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 1, 0, 0);
            lit("d5_pop", b5.top_data, WRAP ? 7 - i : 5 - i);
        end
        step(0, 0, 1, 0, 0);
        lit("d5_empty", b5.empty, 1);

        // Random traffic with alternating push-heavy / pop-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int pw;
            bit r, p, po, c;
            pw = ((i / 150) % 2) ? 70 : 35;
            r  = ($urandom_range(0, 199) == 0);
            p  = ($urandom_range(0, 99) < pw);
            po = ($urandom_range(0, 99) < 100 - pw);
            c  = ($urandom_range(0, 15) == 0);
            step(r, p, po, DW'($urandom), c);
        end

        @(negedge clk);
        armed = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
